// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file writeback port arbiter.
// Holds the arbiter FSM encoding and the default sizing of the
// multi-cycle result buffer and starvation limit.
package wb_port_arbiter_pkg;

  localparam int WB_FIFO_DEPTH = 2;   // default result buffer entries
  localparam int WB_STARVE_LIM = 8;   // default blocked cycles before stall
  localparam int WB_ADDR_W     = 4;
  localparam int WB_DATA_W     = 32;

  // IDLE   : result buffer empty
  // DRAIN  : buffer holds results, counting cycles the head is blocked
  // STARVE : pipeline is being frozen so the head can write
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    STARVE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Result buffer for multi-cycle unit writebacks.
// Strict FIFO with wrap-around pointers. Exposes per-slot valid bits and
// addresses so the arbiter can run a hazard compare against every entry.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, push_addr,
//   push_data        : enqueue (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   count            : number of valid entries
//   head_addr/data   : oldest entry
//   entry_vld/addr   : per-slot valid flag and destination register
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [WB_ADDR_W-1:0]             push_addr,
  input  logic [WB_DATA_W-1:0]             push_data,
  input  logic                             pop,
  output logic [CW-1:0]                    count,
  output logic [WB_ADDR_W-1:0]             head_addr,
  output logic [WB_DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0]                 entry_vld,
  output logic [DEPTH-1:0][WB_ADDR_W-1:0]  entry_addr
);

  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    rd_ptr;
  logic [DEPTH-1:0][WB_ADDR_W-1:0]  addr_mem;
  logic [WB_DATA_W-1:0]             data_mem [DEPTH];
  logic                             push_ok;
  logic                             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ok = push && (count < CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  // Control state. A push and a pop never target the same slot: that would
  // need the buffer to be both empty and full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr            <= ptr_inc(wr_ptr);
        entry_vld[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr            <= ptr_inc(rd_ptr);
        entry_vld[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; entry_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign entry_addr = addr_mem;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the pipeline writeback stage and
// a buffered multi-cycle unit. Pipeline writes always win; buffered results
// fill idle slots, and a starvation FSM freezes the pipeline when the buffer
// head has been blocked too long.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   we/dst_addr/rf_w_data_DM_WB    : pipeline writeback request
//   mc_vld/mc_addr/mc_data, mc_rdy : multi-cycle result handshake
//   hz_addr, hz_pending            : decode hazard query on buffered results
//   stall_pipe                     : registered pipeline freeze request
//   rf_we/rf_w_addr/rf_w_data      : registered register-file write
//   dbg_state                      : current arbiter FSM state
//
// Handshake: a result transfers on a rising edge where mc_vld and mc_rdy are
// both 1. mc_rdy comes only from the registered fill level, so it does not
// depend on mc_vld or on a pop in the same cycle. The producer holds mc_vld,
// mc_addr and mc_data stable until the transfer edge.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_LIM = WB_STARVE_LIM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_DM_WB,
  input  logic [WB_ADDR_W-1:0]  dst_addr_DM_WB,
  input  logic [WB_DATA_W-1:0]  rf_w_data_DM_WB,
  input  logic                  mc_vld,
  input  logic [WB_ADDR_W-1:0]  mc_addr,
  input  logic [WB_DATA_W-1:0]  mc_data,
  output logic                  mc_rdy,
  input  logic [WB_ADDR_W-1:0]  hz_addr,
  output logic                  hz_pending,
  output logic                  stall_pipe,
  output logic                  rf_we,
  output logic [WB_ADDR_W-1:0]  rf_w_addr,
  output logic [WB_DATA_W-1:0]  rf_w_data,
  output arb_state_t            dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIM);

  logic [CW-1:0]                         count;
  logic [WB_ADDR_W-1:0]                  head_addr;
  logic [WB_DATA_W-1:0]                  head_data;
  logic [FIFO_DEPTH-1:0]                 entry_vld;
  logic [FIFO_DEPTH-1:0][WB_ADDR_W-1:0]  entry_addr;

  logic       push;
  logic       pop;
  logic       last_entry;
  arb_state_t state, state_nxt;
  logic [3:0] blk_cnt, blk_cnt_nxt;
  logic       stall_nxt;

  assign mc_rdy     = (count < CW'(FIFO_DEPTH));
  assign push       = mc_vld && mc_rdy;
  // Head writes only into a slot the pipeline leaves free; a result pushed
  // this cycle is not visible as head until the next cycle, so no bypass.
  assign pop        = !we_DM_WB && (count != '0);
  assign last_entry = (count == CW'(1));

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (mc_addr),
    .push_data  (mc_data),
    .pop        (pop),
    .count      (count),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .entry_vld  (entry_vld),
    .entry_addr (entry_addr)
  );

  // A head being popped stays valid in the buffer until the edge that
  // registers its write, so it keeps flagging the hazard this cycle.
  always_comb begin
    hz_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i] == hz_addr)) hz_pending = 1'b1;
    end
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
    end else if (we_DM_WB) begin
      rf_we     <= 1'b1;
      rf_w_addr <= dst_addr_DM_WB;
      rf_w_data <= rf_w_data_DM_WB;
    end else if (pop) begin
      rf_we     <= 1'b1;
      rf_w_addr <= head_addr;
      rf_w_data <= head_data;
    end else begin
      rf_we     <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      blk_cnt    <= '0;
      stall_pipe <= 1'b0;
    end else begin
      state      <= state_nxt;
      blk_cnt    <= blk_cnt_nxt;
      stall_pipe <= stall_nxt;
    end
  end

  // FSM next state. In DRAIN a non-popping cycle always means the head was
  // blocked by a pipeline write, since the buffer is non-empty there.
  always_comb begin
    state_nxt   = state;
    blk_cnt_nxt = blk_cnt;
    stall_nxt   = 1'b0;
    case (state)
      IDLE: begin
        blk_cnt_nxt = '0;
        if (push) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop) begin
          blk_cnt_nxt = '0;
          if (last_entry && !push) state_nxt = IDLE;
        end else if (we_DM_WB) begin
          blk_cnt_nxt = blk_cnt + 4'd1;
          if (blk_cnt_nxt >= STARVE_LIM4) begin
            state_nxt = STARVE;
            stall_nxt = 1'b1;
          end
        end
      end
      STARVE: begin
        // Stall holds even if the pipeline still writes this cycle.
        stall_nxt = 1'b1;
        if (pop) begin
          stall_nxt   = 1'b0;
          blk_cnt_nxt = '0;
          state_nxt   = (last_entry && !push) ? IDLE : DRAIN;
        end
      end
      default: begin
        state_nxt   = IDLE;
        blk_cnt_nxt = '0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_DM_WB = 1'b0;
  logic [3:0]  dst_addr_DM_WB = '0;
  logic [31:0] rf_w_data_DM_WB = '0;
  logic        mc_vld = 1'b0;
  logic [3:0]  mc_addr = '0;
  logic [31:0] mc_data = '0;
  logic        mc_rdy;
  logic [3:0]  hz_addr = '0;
  logic        hz_pending;
  logic        stall_pipe;
  logic        rf_we;
  logic [3:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  arb_state_t  dbg_state;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .we_DM_WB        (we_DM_WB),
    .dst_addr_DM_WB  (dst_addr_DM_WB),
    .rf_w_data_DM_WB (rf_w_data_DM_WB),
    .mc_vld          (mc_vld),
    .mc_addr         (mc_addr),
    .mc_data         (mc_data),
    .mc_rdy          (mc_rdy),
    .hz_addr         (hz_addr),
    .hz_pending      (hz_pending),
    .stall_pipe      (stall_pipe),
    .rf_we           (rf_we),
    .rf_w_addr       (rf_w_addr),
    .rf_w_data       (rf_w_data),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [35:0] exp_q[$];   // expected writes, arbitration order
  logic [35:0] mdl_q[$];   // reference result buffer contents
  logic        mdl_we = 1'b0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every edge, rf_we must match the reference, and each
  // write must be the next expected one.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check("rf_we", 36'(rf_we), 36'(mdl_we));
      if (rf_we === 1'b1 && mdl_we && exp_q.size() > 0) begin
        check("wr_order", {rf_w_addr, rf_w_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at posedge+1 with inputs driven; leaves at next posedge+1.
  task automatic cycle();
    logic exp_rdy;
    logic exp_hz;
    #2;
    exp_rdy = (mdl_q.size() < WB_FIFO_DEPTH);
    exp_hz  = 1'b0;
    foreach (mdl_q[i]) if (mdl_q[i][35:32] == hz_addr) exp_hz = 1'b1;
    check("mc_rdy", 36'(mc_rdy), 36'(exp_rdy));
    check("hz_pending", 36'(hz_pending), 36'(exp_hz));
    mdl_we = 1'b0;
    if (we_DM_WB) begin
      exp_q.push_back({dst_addr_DM_WB, rf_w_data_DM_WB});
      mdl_we = 1'b1;
    end else if (mdl_q.size() > 0) begin
      exp_q.push_back(mdl_q.pop_front());
      mdl_we = 1'b1;
    end
    if (mc_vld && exp_rdy) mdl_q.push_back({mc_addr, mc_data});
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [3:0] a, input logic [31:0] d);
    we_DM_WB = we; dst_addr_DM_WB = a; rf_w_data_DM_WB = d;
  endtask

  task automatic mc(input logic v, input logic [3:0] a, input logic [31:0] d);
    mc_vld = v; mc_addr = a; mc_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    mdl_we = 1'b0;
    mdl_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    pipe(1'b0, 4'd0, 32'd0);
    mc(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    check("rst_rf_we", 36'(rf_we), 36'd0);
    check("rst_stall", 36'(stall_pipe), 36'd0);
    check("rst_mc_rdy", 36'(mc_rdy), 36'd1);
    check("rst_state", 36'(dbg_state), 36'(IDLE));

    // Pipeline-only write appears the next cycle.
    pipe(1'b1, 4'd3, 32'h0000_1234);
    cycle();
    check("pipe_we", 36'(rf_we), 36'd1);
    check("pipe_wr", {rf_w_addr, rf_w_data}, {4'd3, 32'h0000_1234});
    drain(1);

    // Idle push: no bypass, written two cycles after the push.
    hz_addr = 4'd5;
    mc(1'b1, 4'd5, 32'hDEAD_BEEF);
    cycle();
    mc(1'b0, 4'd0, 32'd0);
    check("idle_nobypass", 36'(rf_we), 36'd0);
    check("idle_hz", 36'(hz_pending), 36'd1);
    check("idle_state", 36'(dbg_state), 36'(DRAIN));
    cycle();
    check("idle_wr", {rf_w_addr, rf_w_data}, {4'd5, 32'hDEAD_BEEF});
    check("idle_back", 36'(dbg_state), 36'(IDLE));
    drain(1);

    // Collision: pipeline owns three cycles, buffered result on the fourth.
    hz_addr = 4'd7;
    mc(1'b1, 4'd7, 32'h7777_0007);
    for (int i = 0; i < 3; i++) begin
      pipe(1'b1, 4'(i + 1), 32'h1000 + 32'(i));
      cycle();
      mc(1'b0, 4'd0, 32'd0);
    end
    pipe(1'b0, 4'd0, 32'd0);
    cycle();
    check("coll_wr", {rf_w_addr, rf_w_data}, {4'd7, 32'h7777_0007});
    drain(2);

    // Full buffer under continuous pipeline writes.
    pipe(1'b1, 4'd1, 32'hAAAA_0001);
    mc(1'b1, 4'd4, 32'h4444_0004);
    cycle();
    mc(1'b1, 4'd6, 32'h6666_0006);
    cycle();
    check("full_rdy", 36'(mc_rdy), 36'd0);
    mc(1'b1, 4'd8, 32'h8888_0008);
    cycle();
    cycle();
    check("full_hold", 36'(mc_rdy), 36'd0);
    pipe(1'b0, 4'd0, 32'd0);
    cycle();
    check("full_pop1", {rf_w_addr, rf_w_data}, {4'd4, 32'h4444_0004});
    check("full_rdy_after_pop", 36'(mc_rdy), 36'd1);
    cycle();
    mc(1'b0, 4'd0, 32'd0);
    drain(3);

    // Starvation: eight blocked cycles raise stall_pipe.
    pipe(1'b1, 4'd2, 32'h2222_0000);
    mc(1'b1, 4'd9, 32'hA5A5_5A5A);
    cycle();
    mc(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      pipe(1'b1, 4'd2, 32'h2222_0001 + 32'(i));
      cycle();
    end
    check("stall_early", 36'(stall_pipe), 36'd0);
    cycle();
    check("stall_set", 36'(stall_pipe), 36'd1);
    check("starve_state", 36'(dbg_state), 36'(STARVE));
    pipe(1'b1, 4'd11, 32'hBBBB_000B);
    cycle();
    check("stall_pipe_wins", {rf_w_addr, rf_w_data}, {4'd11, 32'hBBBB_000B});
    check("stall_persist", 36'(stall_pipe), 36'd1);
    pipe(1'b0, 4'd0, 32'd0);
    cycle();
    check("starve_wr", {rf_w_addr, rf_w_data}, {4'd9, 32'hA5A5_5A5A});
    check("stall_clear", 36'(stall_pipe), 36'd0);
    check("starve_idle", 36'(dbg_state), 36'(IDLE));
    drain(1);

    // Random traffic against the reference buffer.
    for (int i = 0; i < 300; i++) begin
      pipe(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
      mc(1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), $urandom());
      hz_addr = 4'($urandom_range(0, 15));
      cycle();
    end
    drain(4);

    // Reset with two buffered entries and STARVE active.
    pipe(1'b1, 4'd1, 32'h0101_0101);
    mc(1'b1, 4'd10, 32'h0A0A_0A0A);
    cycle();
    mc(1'b1, 4'd11, 32'h0B0B_0B0B);
    cycle();
    mc(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 20 && stall_pipe !== 1'b1; i++) cycle();
    check("rst_pre_starve", 36'(stall_pipe), 36'd1);
    hz_addr = 4'd10;
    mc(1'b1, 4'd12, 32'h0C0C_0C0C);
    do_reset();
    check("rst2_rf_we", 36'(rf_we), 36'd0);
    check("rst2_wr", {rf_w_addr, rf_w_data}, 36'd0);
    check("rst2_stall", 36'(stall_pipe), 36'd0);
    check("rst2_mc_rdy", 36'(mc_rdy), 36'd1);
    check("rst2_hz", 36'(hz_pending), 36'd0);
    check("rst2_state", 36'(dbg_state), 36'(IDLE));
    drain(4);

    check("scoreboard_empty", 36'(exp_q.size()), 36'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
